// File: rtl/display_timings_gen.sv
// display_timings_gen: free-running raster timing generator for the DVI path.
// Produces pixel coordinates, sync pulses, display enable and line/frame
// strobes, all registered and describing the same pixel in the same cycle.
// Optional: define DISPLAY_TIMINGS_FRAME_COUNT_EN to add the o_frame_count port.
module display_timings_gen #(
  parameter int CORDW  = 16,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             i_pix_clk,
  input  logic             i_rst_n,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [1:0]       o_ctrl,
  output logic             o_line,
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  output logic             o_frame,
  output logic [CORDW-1:0] o_frame_count
`else
  output logic             o_frame
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

  logic [CORDW-1:0] sx_nxt, sy_nxt;
  logic             de_nxt, hs_nxt, vs_nxt, line_nxt, frame_nxt;

  // Next position and its flags; decoding the next position (rather than the
  // current one) keeps every registered flag aligned with its coordinates.
  always_comb begin
    sx_nxt = o_sx + 1'b1;
    sy_nxt = o_sy;
    if (o_sx == H_LAST) begin
      sx_nxt = '0;
      if (o_sy == V_LAST) sy_nxt = '0;
      else                sy_nxt = o_sy + 1'b1;
    end
    de_nxt    = (sx_nxt < H_ACT) && (sy_nxt < V_ACT);
    hs_nxt    = ((sx_nxt >= HS_BEG) && (sx_nxt < HS_END)) ? H_POL : ~H_POL;
    vs_nxt    = ((sy_nxt >= VS_BEG) && (sy_nxt < VS_END)) ? V_POL : ~V_POL;
    line_nxt  = (sx_nxt == '0);
    frame_nxt = (sx_nxt == '0) && (sy_nxt == '0);
  end

  // Output registers; reset parks on the last back-porch pixel so the first
  // edge after release lands on (0,0).
  always_ff @(posedge i_pix_clk) begin
    if (!i_rst_n) begin
      o_sx    <= H_LAST;
      o_sy    <= V_LAST;
      o_de    <= 1'b0;
      o_hs    <= ~H_POL;
      o_vs    <= ~V_POL;
      o_ctrl  <= {~V_POL, ~H_POL};
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_sx    <= sx_nxt;
      o_sy    <= sy_nxt;
      o_de    <= de_nxt;
      o_hs    <= hs_nxt;
      o_vs    <= vs_nxt;
      o_ctrl  <= {vs_nxt, hs_nxt};
      o_line  <= line_nxt;
      o_frame <= frame_nxt;
    end
  end

`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  logic first_seen;

  // Frame counter; the first frame after reset is frame 0, later strobes count up.
  always_ff @(posedge i_pix_clk) begin
    if (!i_rst_n) begin
      o_frame_count <= '0;
      first_seen    <= 1'b0;
    end else if (frame_nxt) begin
      if (first_seen) o_frame_count <= o_frame_count + 1'b1;
      first_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/display_timings_gen.md
Name: display_timings_gen

Overview:
- Generates raster timing for the DVI output path: horizontal/vertical pixel counters, sync pulses, display enable and frame/line strobes.
- Sits directly upstream of the DVI generator. o_de drives its i_de; o_ctrl drives its channel-0 control input ({vsync, hsync}).
- o_sx/o_sy feed the pixel/colour source that produces the 8-bit channel data.
- Runs in the pixel clock domain only.

Parameters:
- CORDW, 16, width of o_sx/o_sy/o_frame_count; must hold H_TOTAL-1 and V_TOTAL-1.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels (>=0).
- H_SYNC, 96, hsync width in pixels (>=1).
- H_BP, 48, horizontal back porch in pixels (>=0).
- V_RES, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines (>=0).
- V_SYNC, 2, vsync width in lines (>=1).
- V_BP, 33, vertical back porch in lines (>=0).
- H_POL, 0, hsync asserted level (0 = active-low).
- V_POL, 0, vsync asserted level (0 = active-low).

Ports:
- i_pix_clk  in  1  pixel clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- o_sx  out  CORDW  horizontal position, 0..H_TOTAL-1.
- o_sy  out  CORDW  vertical position, 0..V_TOTAL-1.
- o_hs  out  1  horizontal sync, polarity per H_POL.
- o_vs  out  1  vertical sync, polarity per V_POL.
- o_de  out  1  display enable; high in the active area.
- o_ctrl  out  2  {o_vs, o_hs}, for the channel-0 TMDS control input.
- o_line  out  1  one-cycle strobe at the start of every line.
- o_frame  out  1  one-cycle strobe at the start of every frame.
- o_frame_count  out  CORDW  frame counter; present only with the optional feature.

Behaviour:
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
- Single clock: i_pix_clk. Reset is synchronous, active-low (i_rst_n sampled on the rising edge of i_pix_clk).
- Line order per line: active 0..H_RES-1, then front porch, then sync, then back porch.
- Frame order uses the same structure on sy.
- Counters:
  - sx increments each cycle.
  - When sx == H_TOTAL-1: sx wraps to 0 and sy increments.
  - When sx == H_TOTAL-1 and sy == V_TOTAL-1: both wrap to 0.
- All outputs are registered and mutually consistent. Every flag describes the (o_sx, o_sy) presented in the same cycle; there is no skew between coordinates and flags.
- Decode rules:
  - o_de = (sx < H_RES) && (sy < V_RES).
  - hsync asserted when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC, on every line including vertical blanking.
  - vsync asserted when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, for the entire line, transitioning at sx == 0.
  - o_line = (sx == 0).
  - o_frame = (sx == 0 && sy == 0).
- Reset (i_rst_n low at a clock edge):
  - o_sx = H_TOTAL-1, o_sy = V_TOTAL-1.
  - o_de = 0, o_line = 0, o_frame = 0.
  - o_hs = !H_POL and o_vs = !V_POL (deasserted); o_ctrl to match.
  - This is the last back-porch pixel, so outputs are self-consistent.
- First edge after reset release: o_sx = 0, o_sy = 0, o_de = 1, o_line = 1, o_frame = 1.
- Reset mid-frame: takes effect at the next edge regardless of position. Sync pulses are cut short with no glitch beyond that edge.
- Reset held: outputs stay at reset values.
- No input handshake: the block free-runs, emitting one position per clock.

Optional Feature:
- Macro: DISPLAY_TIMINGS_FRAME_COUNT_EN.
- Defined:
  - Port o_frame_count exists; reset value 0.
  - Increments by 1 in the same cycle o_frame asserts, except the first o_frame after reset, which leaves it at 0.
  - Wraps 2^CORDW-1 -> 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release, defaults: hold i_rst_n=0 for 3 cycles, then 1.
  - During reset: o_sx=799, o_sy=524, o_de=0, o_hs=1, o_vs=1.
  - First cycle after release: o_sx=0, o_sy=0, o_de=1, o_frame=1.
- Horizontal timing, defaults, line sy=0:
  - o_de high for sx 0..639 (640 cycles), low for sx 640..799.
  - o_hs low exactly for sx 656..751 (96 cycles).
  - o_line pulses every 800 cycles.
- Vertical timing and frame period, defaults:
  - o_vs low for sy 490..491 (1600 cycles), changing only when sx=0.
  - o_de never high for sy >= 480.
  - o_frame period exactly 420000 cycles.
- Tiny mode (H_RES=4, H_FP=1, H_SYNC=2, H_BP=1, V_RES=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, V_POL=1):
  - H_TOTAL=8, V_TOTAL=5.
  - o_hs high at sx 5..6; o_vs high on sy 3.
  - Wrap (7,4)->(0,0) with o_frame=1.
  - o_ctrl == {o_vs, o_hs} every cycle.
- Mid-frame reset at (sx=700, sy=300), defaults: the cycle after the i_rst_n=0 edge shows o_sx=799, o_sy=524; after release, restart at (0,0) with o_frame=1.
- With DISPLAY_TIMINGS_FRAME_COUNT_EN, tiny mode over 4 frames: o_frame_count reads 0, 1, 2, 3 at successive o_frame strobes. A reset clears it to 0.
